cnnip_mem_master: RTL and testbench

- Single-outstanding initiator for the CNN IP block-memory port protocol (en/we/addr/din/dout/valid).
- Accepts a burst command (read or write, start byte address, word count) and walks consecutive 32-bit words.
- Reads: issues one request at a time, waits for the slave's valid, then presents each word on a valid/ready output stream.
- Writes: drains a valid/ready input stream into memory. Sits between accelerator datapaths and a block-memory wrapper port.

---
 rtl/cnnip_mem_master_if.sv | 41 ++++
 rtl/cnnip_mem_master.sv | 176 +++++++++++++++++
 tb/tb_cnnip_mem_master.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnnip_mem_master_if.sv
// Bus bundle for the CNN IP memory master: command, read stream, write stream,
// block-memory port and status, with master (DUT) and slave (environment) views.
interface cnnip_mem_master_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 10
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  mem_valid;
  logic                  busy;
  logic                  done;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, rd_ready,
           wr_data, wr_valid, mem_dout, mem_valid,
    output cmd_ready, rd_data, rd_valid, wr_ready, mem_en, mem_we,
           mem_addr, mem_din, busy, done
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, rd_ready,
           wr_data, wr_valid, mem_dout, mem_valid,
    input  cmd_ready, rd_data, rd_valid, wr_ready, mem_en, mem_we,
           mem_addr, mem_din, busy, done
  );
endinterface

// File: rtl/cnnip_mem_master.sv
// Single-outstanding burst initiator for the CNN IP block-memory port: walks
// consecutive words, streaming reads out and draining a write stream into memory.
module cnnip_mem_master #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 10
) (
  input  logic clk,
  input  logic arst_q,
  cnnip_mem_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_REQ = 3'd1,
    S_RD_OUT = 3'd2,
    S_WR     = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LP_ADDR_STEP = ADDR_WIDTH'(3'd4);
  localparam logic [ADDR_WIDTH-1:0] LP_ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]  LP_LEN_ZERO  = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]  LP_LEN_ONE   = LEN_WIDTH'(1'b1);
  localparam logic [DATA_WIDTH-1:0] LP_DATA_ZERO = {DATA_WIDTH{1'b0}};

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_last;
  logic [1:0]            w_unused_addr_lsb;

  assign w_last            = (r_remaining == LP_LEN_ONE);
  assign w_unused_addr_lsb = bus.cmd_addr[1:0];

  // State register
  always_ff @(posedge clk or posedge arst_q) begin
    if (arst_q) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Burst address, remaining word count and captured read word
  always_ff @(posedge clk or posedge arst_q) begin
    if (arst_q) begin
      r_addr      <= LP_ADDR_ZERO;
      r_remaining <= LP_LEN_ZERO;
      r_data      <= LP_DATA_ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_addr      <= {bus.cmd_addr[ADDR_WIDTH-1:2], 2'b00};
            r_remaining <= bus.cmd_len;
          end
        end
        S_RD_REQ: begin
          if (bus.mem_valid) begin
            r_data <= bus.mem_dout;
          end
        end
        S_RD_OUT: begin
          if (bus.rd_ready) begin
            r_addr      <= r_addr + LP_ADDR_STEP;
            r_remaining <= r_remaining - LP_LEN_ONE;
          end
        end
        S_WR: begin
          if (bus.wr_valid) begin
            r_addr      <= r_addr + LP_ADDR_STEP;
            r_remaining <= r_remaining - LP_LEN_ONE;
          end
        end
        default: begin
          r_addr <= r_addr;
        end
      endcase
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!bus.cmd_valid) begin
          w_next_state = S_IDLE;
        end else if (bus.cmd_len == LP_LEN_ZERO) begin
          w_next_state = S_DONE;
        end else if (bus.cmd_write) begin
          w_next_state = S_WR;
        end else begin
          w_next_state = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (bus.mem_valid) begin
          w_next_state = S_RD_OUT;
        end else begin
          w_next_state = S_RD_REQ;
        end
      end
      S_RD_OUT: begin
        if (!bus.rd_ready) begin
          w_next_state = S_RD_OUT;
        end else if (w_last) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RD_REQ;
        end
      end
      S_WR: begin
        if (bus.wr_valid && w_last) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_WR;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Output decode; RD_OUT keeps mem_en low so the slave always sees an idle gap
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.rd_data   = LP_DATA_ZERO;
    bus.rd_valid  = 1'b0;
    bus.wr_ready  = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = LP_ADDR_ZERO;
    bus.mem_din   = LP_DATA_ZERO;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
      end
      S_RD_REQ: begin
        bus.busy     = 1'b1;
        bus.mem_en   = 1'b1;
        bus.mem_addr = r_addr;
      end
      S_RD_OUT: begin
        bus.busy     = 1'b1;
        bus.rd_valid = 1'b1;
        bus.rd_data  = r_data;
      end
      S_WR: begin
        bus.busy     = 1'b1;
        bus.wr_ready = 1'b1;
        bus.mem_en   = bus.wr_valid;
        bus.mem_we   = bus.wr_valid;
        bus.mem_addr = r_addr;
        bus.mem_din  = bus.wr_data;
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cnnip_mem_master.sv
// Directed bench for cnnip_mem_master: table of read bursts plus hand-written
// reset, write-wrap and zero-length sequences against a latency-programmable slave.
module tb_cnnip_mem_master;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LW = 10;

  typedef struct {
    logic [AW-1:0]       addr;
    logic [LW-1:0]       len;
    int                  lat;
    int                  stall_word;
    int                  cpw;
    logic [3:0][AW-1:0]  exp_addr;
    logic [3:0][DW-1:0]  exp_data;
  } rd_vec_t;

  logic clk;
  logic arst_q;
  int   n_checks;
  int   n_errors;
  int   slave_lat;
  int   s_cnt;
  logic [DW-1:0] mem [256];
  logic [AW-1:0] log_addr [8];
  logic [DW-1:0] log_data [8];
  int   log_n;
  rd_vec_t vecs [5];
  logic [DW-1:0] wdat [4];
  logic [AW-1:0] waddr [4];

  cnnip_mem_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  cnnip_mem_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk    (clk),
    .arst_q (arst_q),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block-memory slave: reads answer mem_valid after slave_lat cycles of mem_en
  always @(posedge clk or posedge arst_q) begin
    if (arst_q) begin
      bus.mem_valid <= 1'b0;
      bus.mem_dout  <= 32'hDEAD_BEEF;
      s_cnt         <= 0;
      log_n         <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      for (int i = 0; i < 4; i++) mem[64 + i] <= 32'hA0 + 32'(i);
    end else begin
      bus.mem_dout <= 32'hDEAD_BEEF;
      if (bus.mem_en && bus.mem_we) begin
        mem[bus.mem_addr[AW-1:2]] <= bus.mem_din;
        if (log_n < 8) begin
          log_addr[log_n] <= bus.mem_addr;
          log_data[log_n] <= bus.mem_din;
        end
        log_n <= log_n + 1;
      end
      if (bus.mem_valid) begin
        bus.mem_valid <= 1'b0;
        s_cnt         <= 0;
      end else if (bus.mem_en && !bus.mem_we) begin
        if (s_cnt == slave_lat - 1) begin
          bus.mem_valid <= 1'b1;
          bus.mem_dout  <= mem[bus.mem_addr[AW-1:2]];
        end else begin
          s_cnt <= s_cnt + 1;
        end
      end else begin
        s_cnt <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    bus.rd_ready  = 1'b1;
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_read(input int vi);
    rd_vec_t v;
    int cyc, words, reqs, dn, stall, last_acc;
    logic prev_en;
    v = vecs[vi];
    cyc = 0; words = 0; reqs = 0; dn = 0; stall = 0; last_acc = 0; prev_en = 1'b0;
    slave_lat = v.lat;
    issue(1'b0, v.addr, v.len);
    while (dn == 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      chk($sformatf("r%0d_no_we", vi), 32'(bus.mem_we), 0);
      chk($sformatf("r%0d_excl", vi), 32'(bus.rd_valid & bus.wr_ready), 0);
      if (bus.mem_en) begin
        if (!prev_en) reqs++;
        if (reqs >= 1 && reqs <= 4)
          chk($sformatf("r%0d_addr%0d", vi, reqs - 1), 32'(bus.mem_addr), 32'(v.exp_addr[reqs-1]));
      end
      prev_en = bus.mem_en;
      if (bus.done) begin
        dn++;
        chk($sformatf("r%0d_done_busy", vi), 32'(bus.busy), 1);
        chk($sformatf("r%0d_done_cmdrdy", vi), 32'(bus.cmd_ready), 0);
      end else if (bus.rd_valid) begin
        if (words < 4) chk($sformatf("r%0d_data%0d", vi, words), bus.rd_data, v.exp_data[words]);
        if (words == v.stall_word && stall < 5) begin
          bus.rd_ready = 1'b0;
          stall++;
          chk($sformatf("r%0d_stall_en", vi), 32'(bus.mem_en), 0);
        end else begin
          bus.rd_ready = 1'b1;
          if (v.cpw != 0 && words > 0)
            chk($sformatf("r%0d_cpw%0d", vi, words), 32'(cyc - last_acc), 32'(v.cpw));
          last_acc = cyc;
          words++;
        end
      end else begin
        bus.rd_ready = 1'b1;
      end
    end
    chk($sformatf("r%0d_done_once", vi), 32'(dn), 1);
    chk($sformatf("r%0d_words", vi), 32'(words), 32'(v.len));
    chk($sformatf("r%0d_reqs", vi), 32'(reqs), 32'(v.len));
    if (v.stall_word >= 0) chk($sformatf("r%0d_stalls", vi), 32'(stall), 5);
    @(negedge clk);
    chk($sformatf("r%0d_post_done", vi), 32'(bus.done), 0);
    chk($sformatf("r%0d_post_busy", vi), 32'(bus.busy), 0);
    chk($sformatf("r%0d_post_cmdrdy", vi), 32'(bus.cmd_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int it, sent, dn, wbase;
    n_checks = 0;
    n_errors = 0;
    slave_lat = 1;
    wdat  = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};
    waddr = '{10'h3F8, 10'h3FC, 10'h000, 10'h004};
    vecs[0] = '{addr:10'h100, len:10'd4, lat:1, stall_word:-1, cpw:3,
                exp_addr:{10'h10C, 10'h108, 10'h104, 10'h100},
                exp_data:{32'hA3, 32'hA2, 32'hA1, 32'hA0}};
    vecs[1] = '{addr:10'h100, len:10'd4, lat:1, stall_word:2, cpw:0,
                exp_addr:{10'h10C, 10'h108, 10'h104, 10'h100},
                exp_data:{32'hA3, 32'hA2, 32'hA1, 32'hA0}};
    vecs[2] = '{addr:10'h103, len:10'd1, lat:1, stall_word:-1, cpw:0,
                exp_addr:{10'h000, 10'h000, 10'h000, 10'h100},
                exp_data:{32'h0, 32'h0, 32'h0, 32'hA0}};
    vecs[3] = '{addr:10'h104, len:10'd3, lat:2, stall_word:-1, cpw:4,
                exp_addr:{10'h000, 10'h10C, 10'h108, 10'h104},
                exp_data:{32'h0, 32'hA3, 32'hA2, 32'hA1}};
    vecs[4] = '{addr:10'h3F8, len:10'd4, lat:1, stall_word:-1, cpw:3,
                exp_addr:{10'h004, 10'h000, 10'h3FC, 10'h3F8},
                exp_data:{32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000}};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.rd_ready  = 1'b0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b0;
    arst_q = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 0);
    arst_q = 1'b0;

    // Asynchronous reset in the middle of a long read request
    slave_lat = 6;
    issue(1'b0, 10'h100, 10'd1);
    @(negedge clk);
    chk("mid_mem_en", 32'(bus.mem_en), 1);
    chk("mid_mem_addr", 32'(bus.mem_addr), 32'h100);
    chk("mid_busy", 32'(bus.busy), 1);
    #3;
    arst_q = 1'b1;
    #1;
    chk("arst_mem_en", 32'(bus.mem_en), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_rd_valid", 32'(bus.rd_valid), 0);
    chk("arst_cmd_ready", 32'(bus.cmd_ready), 1);
    @(negedge clk);
    arst_q = 1'b0;

    for (int i = 0; i < 4; i++) run_read(i);

    // Gapped write burst wrapping past the top of the address space
    wbase = log_n;
    issue(1'b1, 10'h3F8, 10'd4);
    it = 0; sent = 0; dn = 0;
    while (dn == 0 && it < 100) begin
      @(negedge clk);
      it++;
      if (bus.done) begin
        dn++;
        bus.wr_valid = 1'b0;
        chk("wr_done_we", 32'(bus.mem_we), 0);
      end else begin
        if ((it % 2) == 1 && sent < 4) begin
          bus.wr_valid = 1'b1;
          bus.wr_data  = wdat[sent];
          sent++;
        end else begin
          bus.wr_valid = 1'b0;
        end
        #1;
        chk("wr_ready", 32'(bus.wr_ready), 1);
        chk("wr_rd_valid", 32'(bus.rd_valid), 0);
        chk("wr_mem_we", 32'(bus.mem_we), 32'(bus.wr_valid));
        chk("wr_mem_en", 32'(bus.mem_en), 32'(bus.wr_valid));
        if (bus.wr_valid) begin
          chk($sformatf("wr_addr%0d", sent - 1), 32'(bus.mem_addr), 32'(waddr[sent-1]));
          chk($sformatf("wr_din%0d", sent - 1), bus.mem_din, wdat[sent-1]);
        end
      end
    end
    chk("wr_done_once", 32'(dn), 1);
    chk("wr_done_cycle", 32'(it), 8);
    @(negedge clk);
    chk("wr_post_busy", 32'(bus.busy), 0);
    chk("wr_log_n", 32'(log_n - wbase), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wr_log_addr%0d", k), 32'(log_addr[wbase + k]), 32'(waddr[k]));
      chk($sformatf("wr_log_data%0d", k), log_data[wbase + k], wdat[k]);
    end

    run_read(4);

    // Zero-length command: DONE straight after the handshake, memory untouched
    issue(1'b0, 10'h200, 10'd0);
    @(negedge clk);
    chk("z_done", 32'(bus.done), 1);
    chk("z_busy", 32'(bus.busy), 1);
    chk("z_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("z_mem_en", 32'(bus.mem_en), 0);
    @(negedge clk);
    chk("z_done_end", 32'(bus.done), 0);
    chk("z_busy_end", 32'(bus.busy), 0);
    chk("z_cmd_ready_end", 32'(bus.cmd_ready), 1);
    chk("z_mem_en_end", 32'(bus.mem_en), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
